l1d_bus_transfer: RTL and testbench
===================================

L1D_BUS_TRANSFER -- requirements
Module: l1d_bus_transfer

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Core_CacheEn  in  1  core cache access enable.
- FSM_current_state  in  2  main L1D FSM state: 00 Idle, 01 WriteBus, 10 ReadBus, 11 WriteCache.
- wb_addr  in  32  victim line address.
- rb_addr  in  32  miss address, word-granular.
- wb_line  in  128  victim line, word0 = [31:0].
- Bus_Req  out  1  bus request, held until accepted.
- Bus_Wr  out  1  1 = write beat, 0 = read request.
- Bus_Addr  out  32  beat or request address.
- Bus_WData  out  32  write beat data.
- Bus_Ready  in  1  accepts the current Bus_Req.
- Bus_RData  in  32  read beat data.
- Bus_RValid  in  1  read beat valid.
- Transform_WrDone  out  1  one-cycle pulse; feeds RAM_WB_RB_cond.
- Transform_RdDone  out  1  one-cycle pulse; feeds RAM_RB_WC_cond.
- Transform_BusRdDone_cnt  out  1  level flag: a refill completed in this access.
- Transform_RdLine  out  128  assembled refill line.
- Transform_BeatCnt  out  2  current beat index.

Function
REQ-002 SHALL implement the states T_IDLE, T_WR, T_WR_WAIT, T_RA, T_RD and T_RD_WAIT.
REQ-003 In T_IDLE with FSM_current_state == WriteBus, the block SHALL enter T_WR and assert Bus_Req=1, Bus_Wr=1 on the next cycle.
REQ-004 In T_WR, beat n SHALL drive Bus_Addr = {wb_addr[31:4], n[1:0], 2'b00} and Bus_WData = wb_line[32n+31:32n], for n = 0..3 in order.
- A beat advances only on Bus_Req && Bus_Ready.
- Bus_Addr and Bus_WData SHALL stay stable while Bus_Ready is low.
REQ-005 On the 4th write handshake, the block SHALL drop Bus_Req, pulse Transform_WrDone on the next cycle, and enter T_WR_WAIT.
REQ-006 T_WR_WAIT SHALL hold until FSM_current_state != WriteBus, then return to T_IDLE.
REQ-007 In T_IDLE with FSM_current_state == ReadBus, the block SHALL enter T_RA and assert Bus_Req=1, Bus_Wr=0 on the next cycle.
- Bus_Addr = {rb_addr[31:4], start[1:0], 2'b00}, where start is defined in Configuration.
REQ-008 The T_RA handshake SHALL move the block to T_RD and drop Bus_Req.
REQ-009 In T_RD, each Bus_RValid beat k (k = 0..3) SHALL write Transform_RdLine word (start+k) mod 4.
- Bus_RValid outside T_RD SHALL be ignored.
REQ-010 On the 4th read beat, the block SHALL pulse Transform_RdDone on the next cycle, set Transform_BusRdDone_cnt=1, and enter T_RD_WAIT.
REQ-011 T_RD_WAIT SHALL hold until FSM_current_state != ReadBus, then return to T_IDLE.
REQ-012 Transform_BusRdDone_cnt SHALL clear on the first cycle with Core_CacheEn == 0; the clear has priority over a simultaneous set.
REQ-013 If FSM_current_state becomes Idle mid-transfer (T_WR, T_RA or T_RD), the block SHALL abort to T_IDLE: Bus_Req=0, no done pulse, Transform_RdLine not cleared.
REQ-014 Transform_BeatCnt SHALL count handshakes or beats modulo 4 and return to 0 in T_IDLE.
REQ-015 Exactly one of Transform_WrDone or Transform_RdDone SHALL be high in any cycle, or neither.
REQ-016 Outside T_WR and T_RA, Bus_Req SHALL be 0.

Reset
REQ-017 rst_n low SHALL asynchronously force T_IDLE and zero every output, including mid-burst.
REQ-018 After reset is released, the block SHALL start a transfer only on a fresh WriteBus or ReadBus state.

Configuration
REQ-019 With L1D_CRITICAL_WORD_FIRST_EN defined, start = rb_addr[3:2] and the refill wraps.
REQ-020 Without L1D_CRITICAL_WORD_FIRST_EN, start = 0 and the refill is linear; writes are linear in both builds.

Structure
REQ-021 The shared package L1D_pkg SHALL hold:
- the FSM state encodings (Idle, WriteBus, ReadBus, WriteCache);
- LINE_WORDS = 4;
- the T_* state encodings.
REQ-022 The sub-module l1d_line_buffer SHALL hold Transform_RdLine, with a word-index write port; all other logic is flat.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write: WriteBus, wb_addr=0x80001230, wb_line=0x44443333_22221111_... with Bus_Ready=1 -> 4 beats at 0x80001230/34/38/3C, then a WrDone pulse 1 cycle later.
- Write stall: Bus_Ready low for 3 cycles on beat 2 -> Bus_Addr stays at 0x80001238, and WrDone is 3 cycles later than the unstalled run.
- Critical-word refill: ReadBus, rb_addr=0x8000123C, macro on, RData = A, B, C, D -> request addr 0x8000123C; line words[3,0,1,2] = A, B, C, D; RdDone pulses; BusRdDone_cnt=1.
- Linear refill: the same stimulus with the macro off -> request addr 0x80001230; words[0..3] = A, B, C, D.
- Abort: FSM_current_state returns to Idle after beat 1 -> Bus_Req=0 next cycle, no done pulse, T_IDLE.
- Reset during beat 2 of a read -> all outputs 0 immediately; a following ReadBus starts a clean burst.

Source files
------------

// File: rtl/l1d_bus_transfer_pkg.sv
// Shared definitions for the L1D bus transfer engine: main L1D FSM encodings,
// line geometry and transfer-state encodings.
package L1D_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE        = 2'b00,
    FSM_WRITE_BUS   = 2'b01,
    FSM_READ_BUS    = 2'b10,
    FSM_WRITE_CACHE = 2'b11
  } l1d_fsm_e;

  localparam int LINE_WORDS = 4;

  typedef enum logic [2:0] {
    T_IDLE    = 3'd0,
    T_WR      = 3'd1,
    T_WR_WAIT = 3'd2,
    T_RA      = 3'd3,
    T_RD      = 3'd4,
    T_RD_WAIT = 3'd5
  } xfer_state_e;

  // Word-aligned address of word idx within the line containing base.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] idx);
    return {base[31:4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/l1d_bus_transfer_line_buffer.sv
// Refill line storage for the L1D bus transfer engine: four 32-bit words,
// written one word per cycle through an index port, read as a whole line.
module l1d_line_buffer
  import L1D_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [1:0]                 widx_i,
  input  logic [31:0]                wdata_i,
  output logic [LINE_WORDS*32-1:0]   line_o
);

  logic [31:0] word_q [LINE_WORDS];

  // NOTE: this small buffer is a visible output that must read zero out of
  // reset, so it is built from resettable flops rather than an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
    end else if (we_i) begin
      word_q[widx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
    assign line_o[32*g +: 32] = word_q[g];
  end

endmodule

// File: rtl/l1d_bus_transfer.sv
// L1D bus transfer engine: 4-beat victim write-back and 4-beat line refill.
// Define L1D_CRITICAL_WORD_FIRST_EN to start refills at the missed word and wrap.
module l1d_bus_transfer
  import L1D_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Core_CacheEn,
  input  logic [1:0]    FSM_current_state,
  input  logic [31:0]   wb_addr,
  input  logic [31:0]   rb_addr,
  input  logic [127:0]  wb_line,
  output logic          Bus_Req,
  output logic          Bus_Wr,
  output logic [31:0]   Bus_Addr,
  output logic [31:0]   Bus_WData,
  input  logic          Bus_Ready,
  input  logic [31:0]   Bus_RData,
  input  logic          Bus_RValid,
  output logic          Transform_WrDone,
  output logic          Transform_RdDone,
  output logic          Transform_BusRdDone_cnt,
  output logic [127:0]  Transform_RdLine,
  output logic [1:0]    Transform_BeatCnt
);

  xfer_state_e state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        wr_done_q, wr_done_d;
  logic        rd_done_q, rd_done_d;
  logic        rd_flag_q, rd_flag_d;
  logic        armed_q;
  logic        line_we;
  logic [1:0]  line_idx;
  logic [1:0]  start_idx;
  logic        fsm_idle;
  logic        unused_addr_bits;

`ifdef L1D_CRITICAL_WORD_FIRST_EN
  assign start_idx = rb_addr[3:2];
`else
  assign start_idx = 2'b00;
`endif

  assign unused_addr_bits = ^{wb_addr[3:0], rb_addr[3:0]};
  assign fsm_idle         = (FSM_current_state == FSM_IDLE);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    line_we   = 1'b0;
    line_idx  = start_idx + beat_q;
    Bus_Req   = 1'b0;
    Bus_Wr    = 1'b0;
    Bus_Addr  = '0;
    Bus_WData = '0;

    unique case (state_q)
      T_IDLE: begin
        beat_d = 2'd0;
        if (armed_q && FSM_current_state == FSM_WRITE_BUS)     state_d = T_WR;
        else if (armed_q && FSM_current_state == FSM_READ_BUS) state_d = T_RA;
      end
      T_WR: begin
        Bus_Req   = 1'b1;
        Bus_Wr    = 1'b1;
        Bus_Addr  = beat_addr(wb_addr, beat_q);
        Bus_WData = wb_line[{beat_q, 5'd0} +: 32];
        if (fsm_idle) begin
          state_d = T_IDLE;
          beat_d  = 2'd0;
        end else if (Bus_Ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d   = T_WR_WAIT;
            wr_done_d = 1'b1;
          end
        end
      end
      T_WR_WAIT: begin
        if (FSM_current_state != FSM_WRITE_BUS) state_d = T_IDLE;
      end
      T_RA: begin
        Bus_Req  = 1'b1;
        Bus_Addr = beat_addr(rb_addr, start_idx);
        if (fsm_idle)       state_d = T_IDLE;
        else if (Bus_Ready) state_d = T_RD;
      end
      T_RD: begin
        if (fsm_idle) begin
          state_d = T_IDLE;
          beat_d  = 2'd0;
        end else if (Bus_RValid) begin
          line_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d   = T_RD_WAIT;
            rd_done_d = 1'b1;
          end
        end
      end
      T_RD_WAIT: begin
        if (FSM_current_state != FSM_READ_BUS) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase

    // Leaving cache-enabled access wipes the refill flag, even on the set cycle.
    if (!Core_CacheEn)  rd_flag_d = 1'b0;
    else if (rd_done_d) rd_flag_d = 1'b1;
    else                rd_flag_d = rd_flag_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= T_IDLE;
      beat_q    <= 2'd0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_flag_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      rd_flag_q <= rd_flag_d;
      // A request already pending at reset release is stale; wait for a quiet state.
      armed_q   <= armed_q | fsm_idle | (FSM_current_state == FSM_WRITE_CACHE);
    end
  end

  l1d_line_buffer u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (line_we),
    .widx_i  (line_idx),
    .wdata_i (Bus_RData),
    .line_o  (Transform_RdLine)
  );

  assign Transform_WrDone        = wr_done_q;
  assign Transform_RdDone        = rd_done_q;
  assign Transform_BusRdDone_cnt = rd_flag_q;
  assign Transform_BeatCnt       = beat_q;

endmodule

// File: tb/tb_l1d_bus_transfer.sv
// Scoreboard bench for l1d_bus_transfer: stimulus pushes expected bus beats and
// done events; a negedge monitor pops and compares them as the DUT presents them.
module tb_l1d_bus_transfer;
  import L1D_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Core_CacheEn;
  logic [1:0]   FSM_current_state;
  logic [31:0]  wb_addr, rb_addr;
  logic [127:0] wb_line;
  logic         Bus_Req, Bus_Wr, Bus_Ready, Bus_RValid;
  logic [31:0]  Bus_Addr, Bus_WData, Bus_RData;
  logic         Transform_WrDone, Transform_RdDone, Transform_BusRdDone_cnt;
  logic [127:0] Transform_RdLine;
  logic [1:0]   Transform_BeatCnt;

  always #5 clk = ~clk;

  l1d_bus_transfer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .Core_CacheEn            (Core_CacheEn),
    .FSM_current_state       (FSM_current_state),
    .wb_addr                 (wb_addr),
    .rb_addr                 (rb_addr),
    .wb_line                 (wb_line),
    .Bus_Req                 (Bus_Req),
    .Bus_Wr                  (Bus_Wr),
    .Bus_Addr                (Bus_Addr),
    .Bus_WData               (Bus_WData),
    .Bus_Ready               (Bus_Ready),
    .Bus_RData               (Bus_RData),
    .Bus_RValid              (Bus_RValid),
    .Transform_WrDone        (Transform_WrDone),
    .Transform_RdDone        (Transform_RdDone),
    .Transform_BusRdDone_cnt (Transform_BusRdDone_cnt),
    .Transform_RdLine        (Transform_RdLine),
    .Transform_BeatCnt       (Transform_BeatCnt)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic is_rd; logic [127:0] line; logic cnt; } done_t;

  beat_t       exp_beats[$];
  done_t       exp_done[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_words [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_line();
    return {ref_words[3], ref_words[2], ref_words[1], ref_words[0]};
  endfunction

  function automatic int refill_start(input logic [31:0] a);
`ifdef L1D_CRITICAL_WORD_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  // Monitor: compares every accepted bus request and every done pulse.
  always @(negedge clk) begin
    beat_t e;
    done_t d;
    if (rst_n) begin
      check("done_exclusive", Transform_WrDone & Transform_RdDone, 0);
      if (Bus_Req && Bus_Ready) begin
        if (exp_beats.size() == 0) check("unexpected_bus_beat", Bus_Addr, 0);
        else begin
          e = exp_beats.pop_front();
          check("bus_wr", Bus_Wr, e.wr);
          check("bus_addr", Bus_Addr, e.addr);
          if (e.wr) check("bus_wdata", Bus_WData, e.data);
        end
      end
      if (Transform_WrDone || Transform_RdDone) begin
        if (exp_done.size() == 0) check("unexpected_done", {Transform_WrDone, Transform_RdDone}, 0);
        else begin
          d = exp_done.pop_front();
          check("done_kind", {Transform_WrDone, Transform_RdDone}, d.is_rd ? 2'b01 : 2'b10);
          if (d.is_rd) begin
            check("rd_line", Transform_RdLine, d.line);
            check("busrd_done_cnt_at_done", Transform_BusRdDone_cnt, d.cnt);
          end
        end
      end
    end
  end

  task automatic run_write(input logic [31:0] a, input logic [127:0] l, input int stall_beat,
                           input int stall_len, input bit abort1, output int lat);
    int    hs = 0, hs4 = -1, done = -1, left = stall_len, cyc = 0;
    bit    aborted = 0;
    beat_t b;
    wb_addr = a;
    wb_line = l;
    for (int n = 0; n < 4; n++) begin
      if (!abort1 || n == 0) begin
        b.wr   = 1'b1;
        b.addr = line_base(a) + 32'(4 * n);
        b.data = 32'(l >> (32 * n));
        exp_beats.push_back(b);
      end
    end
    if (!abort1) exp_done.push_back('{is_rd: 1'b0, line: '0, cnt: 1'b0});
    @(posedge clk); #1;
    FSM_current_state = FSM_WRITE_BUS;
    Bus_Ready = 1'b1;
    while (done < 0 && !aborted && cyc < 60) begin
      @(posedge clk); #1;
      if (abort1 && hs == 1) begin
        FSM_current_state = FSM_IDLE;
        Bus_Ready = 1'b0;
        aborted = 1;
      end else begin
        Bus_Ready = !(Bus_Req && hs == stall_beat && left > 0);
        if (!Bus_Ready) left--;
      end
      @(negedge clk); cyc++;
      if (Bus_Req && Bus_Ready) begin
        hs++;
        if (hs == 4) hs4 = cyc;
      end else if (Bus_Req && !aborted) begin
        check("stall_addr_stable", Bus_Addr, line_base(a) + 32'(4 * hs));
        check("stall_wdata_stable", Bus_WData, 32'(l >> (32 * hs)));
      end
      if (Transform_WrDone) done = cyc;
    end
    lat = done;
    if (abort1) begin
      @(posedge clk); #1;
      check("abort_bus_req", Bus_Req, 0);
      check("abort_beat_cnt", Transform_BeatCnt, 0);
      check("abort_line_kept", Transform_RdLine, ref_line());
      repeat (4) @(posedge clk);
      #1 Bus_Ready = 1'b1;
    end else begin
      check("wr_done_seen", done >= 0, 1);
      check("wr_done_latency", done - hs4, 1);
      @(posedge clk); #1;
      check("wr_wait_holds", Bus_Req, 0);
      FSM_current_state = FSM_WRITE_CACHE;
      repeat (2) @(posedge clk); #1;
      check("wr_idle_beat_cnt", Transform_BeatCnt, 0);
      FSM_current_state = FSM_IDLE;
    end
  endtask

  // stop_after < 4 ends the refill early: stop_kind 0 aborts via Idle, 1 resets.
  task automatic run_read(input logic [31:0] a, input logic [127:0] words, input int stop_after,
                          input int stop_kind, input bit clear_on_last);
    int          start, cyc = 0;
    bit          req_seen = 0, got = 0;
    beat_t       b;
    logic [31:0] pred [4];
    logic [31:0] w;
    start = refill_start(a);
    rb_addr = a;
    b.wr = 1'b0; b.addr = line_base(a) + 32'(4 * start); b.data = '0;
    exp_beats.push_back(b);
    for (int i = 0; i < 4; i++) pred[i] = ref_words[i];
    for (int k = 0; k < 4; k++) pred[(start + k) % 4] = 32'(words >> (32 * k));
    if (stop_after == 4)
      exp_done.push_back('{is_rd: 1'b1, line: {pred[3], pred[2], pred[1], pred[0]},
                           cnt: !clear_on_last});
    @(posedge clk); #1;
    FSM_current_state = FSM_READ_BUS;
    Bus_Ready  = 1'b1;
    Bus_RValid = 1'b1;
    Bus_RData  = 32'hDEAD_BEEF;
    while (!req_seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (Bus_Req && Bus_Ready) req_seen = 1;
    end
    check("rd_req_seen", req_seen, 1);
    for (int k = 0; k < stop_after; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2 && $urandom_range(0, 3) == 0; g++) begin
        Bus_RValid = 1'b0;
        @(posedge clk); #1;
      end
      w = 32'(words >> (32 * k));
      Bus_RValid = 1'b1;
      Bus_RData  = w;
      ref_words[(start + k) % 4] = w;
      if (k == 3 && clear_on_last) Core_CacheEn = 1'b0;
    end
    @(posedge clk); #1;
    Bus_RValid   = 1'b0;
    Core_CacheEn = 1'b1;
    if (stop_after == 4) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (Transform_RdDone) begin got = 1; break; end
      end
      check("rd_done_seen", got, 1);
      @(posedge clk); #1;
      check("rd_wait_holds", Bus_Req, 0);
      FSM_current_state = FSM_WRITE_CACHE;
      @(posedge clk); #1;
      check("busrd_done_cnt_level", Transform_BusRdDone_cnt, !clear_on_last);
      Core_CacheEn = 1'b0;
      @(posedge clk); #1;
      check("busrd_done_cnt_clear", Transform_BusRdDone_cnt, 0);
      check("rd_idle_beat_cnt", Transform_BeatCnt, 0);
      Core_CacheEn = 1'b1;
      FSM_current_state = FSM_IDLE;
    end else if (stop_kind == 0) begin
      FSM_current_state = FSM_IDLE;
      @(posedge clk); #1;
      check("rd_abort_beat_cnt", Transform_BeatCnt, 0);
      check("rd_abort_line_kept", Transform_RdLine, ref_line());
      repeat (3) @(posedge clk); #1;
    end else begin
      Bus_RValid = 1'b1;
      Bus_RData  = 32'(words >> (32 * stop_after));
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs_zero", {Bus_Req, Bus_Wr, Bus_Addr, Bus_WData, Transform_WrDone,
            Transform_RdDone, Transform_BusRdDone_cnt, Transform_BeatCnt}, 0);
      check("reset_line_zero", Transform_RdLine, 0);
      for (int i = 0; i < 4; i++) ref_words[i] = '0;
      exp_beats.delete();
      exp_done.delete();
      Bus_RValid = 1'b0;
    end
  endtask

  initial begin
    int          lat0, lat1;
    logic [127:0] rnd;
    rst_n = 1'b0;
    Core_CacheEn = 1'b1;
    FSM_current_state = FSM_IDLE;
    wb_addr = '0; rb_addr = '0; wb_line = '0;
    Bus_Ready = 1'b1; Bus_RData = '0; Bus_RValid = 1'b0;
    for (int i = 0; i < 4; i++) ref_words[i] = '0;
    #12;
    check("reset_outputs", {Bus_Req, Bus_Wr, Bus_Addr, Bus_WData, Transform_WrDone,
          Transform_RdDone, Transform_BusRdDone_cnt, Transform_BeatCnt, Transform_RdLine}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_after_reset", {Bus_Req, Transform_BeatCnt}, 0);

    run_write(32'h8000_1230, 128'h88887777_66665555_44443333_22221111, -1, 0, 0, lat0);
    run_write(32'h8000_1230, 128'h88887777_66665555_44443333_22221111, 2, 3, 0, lat1);
    check("stall_latency_delta", lat1 - lat0, 3);

    run_read(32'h8000_123C, 128'hDDDD000D_CCCC000C_BBBB000B_AAAA000A, 4, 0, 0);
    run_write($urandom, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 1, lat0);

    for (int it = 0; it < 4; it++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_write($urandom, rnd, $urandom_range(0, 3), $urandom_range(0, 2), 0, lat0);
      run_read($urandom, {$urandom, $urandom, $urandom, $urandom}, 4, 0, it == 2);
    end

    run_read($urandom, {$urandom, $urandom, $urandom, $urandom}, 2, 0, 0);

    run_read(32'h8000_1234, {$urandom, $urandom, $urandom, $urandom}, 2, 1, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("no_stale_start", Bus_Req, 0);
    FSM_current_state = FSM_IDLE;
    repeat (2) @(posedge clk);
    run_read(32'h8000_1238, 128'h44444444_33333333_22222222_11111111, 4, 0, 0);

    repeat (4) @(posedge clk); #1;
    check("scoreboard_drained", {32'(exp_beats.size()), 32'(exp_done.size())}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
